// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key expansion: accepts one cipher key, then emits round keys
// 0..NUM_ROUNDS one per downstream handshake, holding only the current round key.
module key_schedule_seq #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         keyValid,
    output logic         keyReady,
    input  logic [127:0] key,
    output logic         roundKeyValid,
    input  logic         roundKeyReady,
    output logic [127:0] roundKey,
    output logic [3:0]   round,
    output logic         lastRoundKey
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   rkey_q, rkey_d;
    logic [3:0]     round_q, round_d;
    logic [7:0]     rcon_q, rcon_d;

    logic           key_load;
    logic           emit_hs;
    logic           at_last;
    logic [31:0]    w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [127:0]   next_key;

    assign key_load = (state_q == StIdle) && keyValid;
    assign emit_hs  = (state_q == StEmit) && roundKeyReady;
    assign at_last  = (round_q == LastRound);

    // Next round key is derived only from registered state.
    always_comb begin
        w0 = rkey_q[127:96];
        w1 = rkey_q[95:64];
        w2 = rkey_q[63:32];
        w3 = rkey_q[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (keyValid) state_d = StEmit;
            StEmit: if (roundKeyReady && at_last) state_d = StIdle;
        endcase
    end

    always_comb begin
        rkey_d  = rkey_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        if (key_load) begin
            rkey_d  = key;
            round_d = 4'd0;
            rcon_d  = 8'h01;
        end else if (emit_hs && !at_last) begin
            rkey_d  = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rkey_q  <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else begin
            rkey_q  <= rkey_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        keyReady      = (state_q == StIdle);
        roundKeyValid = (state_q == StEmit);
        lastRoundKey  = (state_q == StEmit) && at_last;
        roundKey      = rkey_q;
        round         = round_q;
    end

    a_key_known : assert property (@(posedge clock) disable iff (reset)
        keyValid |-> !$isunknown(key));
    a_rkey_known : assert property (@(posedge clock) disable iff (reset)
        roundKeyValid |-> !$isunknown(roundKey));
    a_stall_stable : assert property (@(posedge clock) disable iff (reset)
        (roundKeyValid && !roundKeyReady) |=>
            ($stable(roundKey) && $stable(round) && $stable(lastRoundKey)));
    a_round_range : assert property (@(posedge clock) disable iff (reset)
        round_q <= LastRound);

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: a full-schedule reference model compared every cycle,
// directed scenarios plus randomized keys, stalls and resets on two parameterisations.
module tb_key_schedule_seq;

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEYB = 128'h000102030405060708090a0b0c0d0e0f;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         rst [2];
    logic         kv  [2];
    logic         rkr [2];
    logic [127:0] kin [2];
    logic         kr  [2];
    logic         rv  [2];
    logic         lst [2];
    logic [127:0] rk  [2];
    logic [3:0]   rnd [2];

    key_schedule_seq dut0 (
        .clock(clock), .reset(rst[0]), .keyValid(kv[0]), .keyReady(kr[0]), .key(kin[0]),
        .roundKeyValid(rv[0]), .roundKeyReady(rkr[0]), .roundKey(rk[0]), .round(rnd[0]),
        .lastRoundKey(lst[0])
    );

    key_schedule_seq #(.NUM_ROUNDS(2)) dut1 (
        .clock(clock), .reset(rst[1]), .keyValid(kv[1]), .keyReady(kr[1]), .key(kin[1]),
        .roundKeyValid(rv[1]), .roundKeyReady(rkr[1]), .roundKey(rk[1]), .round(rnd[1]),
        .lastRoundKey(lst[1])
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model state: whether a schedule is being emitted, which round, and
    // the whole precomputed schedule for the loaded key.
    bit             m_emit  [2];
    int             m_idx   [2];
    logic [1407:0]  m_sched [2];
    logic [127:0]   m_kin   [2];
    int             nr      [2] = '{10, 2};
    logic [7:0]     sbox    [256];
    logic [7:0]     rc      [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout waiting for schedule to finish (t=%0t)", name, $time);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Standard FIPS-197 word recurrence over all 44 words.
    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [1407:0] s;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc[i / 4], 24'h0};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            s[1407 - 128 * r -: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return s;
    endfunction

    function automatic logic [127:0] model_key(input int inst, input int r);
        return m_sched[inst][1407 - 128 * r -: 128];
    endfunction

    initial forever begin
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_emit[i] = 1'b0;
                m_idx[i]  = 0;
            end else if (!m_emit[i]) begin
                if (kv[i]) begin
                    m_sched[i] = expand(kin[i]);
                    m_kin[i]   = kin[i];
                    m_idx[i]   = 0;
                    m_emit[i]  = 1'b1;
                end
            end else if (rkr[i]) begin
                if (m_idx[i] == nr[i]) m_emit[i] = 1'b0;
                else m_idx[i]++;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("keyReady[%0d]", i), 128'(kr[i]), 128'(!m_emit[i]));
                check($sformatf("roundKeyValid[%0d]", i), 128'(rv[i]), 128'(m_emit[i]));
                check($sformatf("lastRoundKey[%0d]", i), 128'(lst[i]),
                      128'(m_emit[i] && (m_idx[i] == nr[i])));
                if (m_emit[i]) begin
                    check($sformatf("roundKey[%0d] r%0d", i, m_idx[i]), rk[i],
                          model_key(i, m_idx[i]));
                    check($sformatf("round[%0d]", i), 128'(rnd[i]), 128'(m_idx[i]));
                    if (m_kin[i] == FIPS) begin
                        case (m_idx[i])
                            1: check("fips r1", rk[i], 128'ha0fafe1788542cb123a339392a6c7605);
                            2: check("fips r2", rk[i], 128'hf2c295f27a96b9435935807a7359f67f);
                            3: check("fips r3", rk[i], 128'h3d80477d4716fe3e1e237e446d7a883b);
                            4: check("fips r4", rk[i], 128'hef44a541a8525b7fb671253bdb0bad00);
                            10: check("fips r10", rk[i], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                            default: ;
                        endcase
                    end
                    if (m_kin[i] == '0 && m_idx[i] == 1)
                        check("zero r1", rk[i], 128'h62636363626363636263636362636363);
                    if (m_kin[i] == '1 && m_idx[i] == 1)
                        check("ones r1", rk[i], 128'he8e9e9e917161616e8e9e9e917161616);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drive roundKeyReady (always high or random) until the model returns to idle.
    task automatic wait_idle(input int inst, input bit random_ready, input string name);
        int g;
        g = 0;
        while (m_emit[inst] && g < 200) begin
            rkr[inst] = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc();
            g++;
        end
        if (g >= 200) timeout(name);
    endtask

    task automatic load(input int inst, input logic [127:0] k);
        kin[inst] = k;
        kv[inst]  = 1'b1;
        cyc();
        kv[inst]  = 1'b0;
    endtask

    initial begin
        int n, g;
        logic [7:0] inv;
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int j = 2; j < 11; j++) rc[j] = gmul(rc[j - 1], 8'h02);
        check("model sbox[00]", 128'(sbox[0]), 128'h63);
        check("model sbox[53]", 128'(sbox[8'h53]), 128'hed);
        check("model rcon[10]", 128'(rc[10]), 128'h36);

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; kv[i] = 1'b0; rkr[i] = 1'b0; kin[i] = '0;
            m_emit[i] = 1'b0; m_idx[i] = 0; m_sched[i] = '0; m_kin[i] = '0;
        end
        cyc();
        cyc();
        chk_en = 1'b1;
        check("reset keyReady", 128'(kr[0]), 128'h1);
        check("reset roundKeyValid", 128'(rv[0]), 128'h0);
        check("reset roundKey", rk[0], 128'h0);
        check("reset round", 128'(rnd[0]), 128'h0);
        check("reset lastRoundKey", 128'(lst[0]), 128'h0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        cyc();

        // Continuous ready: 11 back-to-back valid cycles.
        rkr[0] = 1'b1;
        load(0, FIPS);
        check("latency round0 key", rk[0], FIPS);
        n = 0; g = 0;
        while (m_emit[0] && g < 50) begin
            if (rv[0]) n++;
            cyc();
            g++;
        end
        check("valid cycle count", 128'(n), 128'd11);
        cyc();

        // Stall at round 3 for 5 cycles.
        load(0, FIPS);
        g = 0;
        while (m_idx[0] != 3 && g < 20) begin cyc(); g++; end
        rkr[0] = 1'b0;
        repeat (5) begin
            cyc();
            check("stall round", 128'(rnd[0]), 128'd3);
        end
        wait_idle(0, 1'b0, "stall");

        // A different key offered throughout EMIT is taken in the first idle cycle.
        load(0, FIPS);
        kin[0] = KEYB;
        kv[0]  = 1'b1;
        wait_idle(0, 1'b0, "offer during emit");
        cyc();
        kv[0] = 1'b0;
        check("late key accepted", rk[0], KEYB);
        check("late key round", 128'(rnd[0]), 128'd0);
        wait_idle(0, 1'b1, "late key");

        // Reset at round 5, then reload.
        load(0, FIPS);
        g = 0;
        while (m_idx[0] != 5 && g < 20) begin cyc(); g++; end
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        check("mid reset valid", 128'(rv[0]), 128'h0);
        check("mid reset round", 128'(rnd[0]), 128'h0);
        check("mid reset keyReady", 128'(kr[0]), 128'h1);
        load(0, FIPS);
        wait_idle(0, 1'b0, "reload");

        // Truncated schedule on the NUM_ROUNDS=2 instance.
        rkr[1] = 1'b1;
        load(1, FIPS);
        n = 0; g = 0;
        while (m_emit[1] && g < 20) begin
            if (rv[1]) n++;
            cyc();
            g++;
        end
        check("truncated valid count", 128'(n), 128'd3);

        // Back-to-back zero then all-ones keys, one idle cycle between.
        kin[0] = '0;
        kv[0]  = 1'b1;
        cyc();
        kin[0] = '1;
        wait_idle(0, 1'b0, "zero key");
        n = 0; g = 0;
        while (!m_emit[0] && g < 10) begin n++; cyc(); g++; end
        kv[0] = 1'b0;
        check("idle cycles between keys", 128'(n), 128'd1);
        wait_idle(0, 1'b0, "ones key");

        // Randomized keys, gaps, stalls and occasional resets on both instances.
        for (int it = 0; it < 30; it++) begin
            int inst;
            inst = it % 2;
            repeat ($urandom_range(0, 2)) cyc();
            load(inst, {$urandom, $urandom, $urandom, $urandom});
            g = 0;
            while (m_emit[inst] && g < 200) begin
                rkr[inst] = ($urandom_range(0, 3) != 0);
                rst[inst] = ($urandom_range(0, 39) == 0);
                cyc();
                g++;
            end
            rst[inst] = 1'b0;
            if (g >= 200) timeout("random");
        end
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
